// File: rtl/redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared types for the frontend redirect logic.
//   - rdr_src_e   : redirect source, encoded as its age rank (WB oldest = 3)
//   - rdr_state_e : redirect_ctrl FSM state
//   - PC_W_DEFAULT: default program-counter width
//   - src_onehot  : rank -> flush pulse vector ordered {wb, priv, ex2, ex1}
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int PC_W_DEFAULT = 32;

  // Encoding equals rank so that "older" is a plain magnitude compare.
  typedef enum logic [1:0] {
    RDR_EX1  = 2'd0,
    RDR_EX2  = 2'd1,
    RDR_PRIV = 2'd2,
    RDR_WB   = 2'd3
  } rdr_src_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } rdr_state_e;

  function automatic logic [3:0] src_onehot(input rdr_src_e src);
    logic [3:0] v;
    v = 4'b0000;
    v[src] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// redirect_ctrl_if: request / flush / redirect bundle around redirect_ctrl.
//   slave  modport: redirect_ctrl side (requests in, flushes + redirect out)
//   master modport: pipeline / IF0 side
//
// Handshake: redirect_valid/if0_ready is a valid/ready pair. The redirect is
// taken in a cycle where both are high. Once redirect_valid rises it stays high
// and redirect_pc stays stable until taken, except that an older source may
// replace the pending target (with its own flush pulse) before it is taken.
// The request inputs are single-cycle strobes with no ready; a request that
// loses arbitration or arrives while busy with an older one is dropped.
// -----------------------------------------------------------------------------
interface redirect_ctrl_if
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
);

  logic            wb_excp_req;
  logic [PC_W-1:0] wb_excp_pc;
  logic            ex2_br_req;
  logic [PC_W-1:0] ex2_br_pc;
  logic            ex1_br_req;
  logic [PC_W-1:0] ex1_br_pc;
  logic            priv_req;
  logic [PC_W-1:0] priv_pc;
  logic            store_empty;
  logic            if0_ready;

  logic            flush_from_wb;
  logic            flush_from_ex2;
  logic            flush_from_ex1;
  logic            flush_by_priv;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            commit_hold;

  modport slave (
    input  wb_excp_req, wb_excp_pc, ex2_br_req, ex2_br_pc, ex1_br_req, ex1_br_pc,
    input  priv_req, priv_pc, store_empty, if0_ready,
    output flush_from_wb, flush_from_ex2, flush_from_ex1, flush_by_priv,
    output redirect_valid, redirect_pc, commit_hold
  );

  modport master (
    output wb_excp_req, wb_excp_pc, ex2_br_req, ex2_br_pc, ex1_br_req, ex1_br_pc,
    output priv_req, priv_pc, store_empty, if0_ready,
    input  flush_from_wb, flush_from_ex2, flush_from_ex1, flush_by_priv,
    input  redirect_valid, redirect_pc, commit_hold
  );

endinterface

// File: rtl/redirect_ctrl_stat.sv
// -----------------------------------------------------------------------------
// redirect_stat: saturating event counters for redirect_ctrl. Only
// instantiated when REDIRECT_STAT_EN is defined.
//   clk, rst     : clock, asynchronous active-high reset
//   i_flush      : flush pulses {wb, priv, ex2, ex1}
//   i_draining   : FSM is in DRAIN this cycle
//   o_cnt_*      : 32-bit saturating counts of each flush source
//   o_cnt_drain  : 32-bit saturating count of DRAIN cycles
// -----------------------------------------------------------------------------
module redirect_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_flush,
  input  logic        i_draining,
  output logic [31:0] o_cnt_wb,
  output logic [31:0] o_cnt_priv,
  output logic [31:0] o_cnt_ex2,
  output logic [31:0] o_cnt_ex1,
  output logic [31:0] o_cnt_drain
);

  logic [31:0] r_cnt [4];
  logic [31:0] r_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      r_drain <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i_flush[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 32'd1;
      end
      if (i_draining && (r_drain != '1)) r_drain <= r_drain + 32'd1;
    end
  end

  assign o_cnt_ex1   = r_cnt[0];
  assign o_cnt_ex2   = r_cnt[1];
  assign o_cnt_priv  = r_cnt[2];
  assign o_cnt_wb    = r_cnt[3];
  assign o_cnt_drain = r_drain;

endmodule

// File: rtl/redirect_ctrl.sv
// -----------------------------------------------------------------------------
// redirect_ctrl: frontend-redirect initiator. Arbitrates redirect requests by
// age (WB > PRIV > EX2 > EX1), emits one-cycle flush pulses, holds the
// redirect target toward IF0 until taken, and stalls commit while a
// privileged refetch waits for the store path to drain.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : redirect_ctrl_if.slave (requests, flushes, redirect, hold)
//   o_dbg_state  : current FSM state
//   stat_*       : event counters, present only with REDIRECT_STAT_EN defined
// Build option: REDIRECT_STAT_EN adds the redirect_stat counter bank.
// -----------------------------------------------------------------------------
module redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  redirect_ctrl_if.slave bus,
  output rdr_state_e     o_dbg_state
`ifdef REDIRECT_STAT_EN
  ,
  output logic [31:0]    stat_wb_cnt,
  output logic [31:0]    stat_priv_cnt,
  output logic [31:0]    stat_ex2_cnt,
  output logic [31:0]    stat_ex1_cnt,
  output logic [31:0]    stat_drain_cnt
`endif
);

  rdr_state_e      r_state;
  rdr_src_e        r_src;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_hold;
  logic [3:0]      r_flush;   // {wb, priv, ex2, ex1}

  logic            w_any;
  rdr_src_e        w_win_src;
  logic [PC_W-1:0] w_win_pc;
  logic            w_overwrite;

  // Oldest requester this cycle.
  always_comb begin
    w_any     = bus.wb_excp_req | bus.priv_req | bus.ex2_br_req | bus.ex1_br_req;
    w_win_src = RDR_EX1;
    w_win_pc  = bus.ex1_br_pc;
    if (bus.wb_excp_req) begin
      w_win_src = RDR_WB;
      w_win_pc  = bus.wb_excp_pc;
    end else if (bus.priv_req) begin
      w_win_src = RDR_PRIV;
      w_win_pc  = bus.priv_pc;
    end else if (bus.ex2_br_req) begin
      w_win_src = RDR_EX2;
      w_win_pc  = bus.ex2_br_pc;
    end
  end

  // Only a strictly older source may replace a pending redirect.
  assign w_overwrite = (r_state == HOLD) && w_any && (w_win_src > r_src);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_src   <= RDR_EX1;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      r_flush <= 4'b0000;
    end else begin
      r_flush <= 4'b0000;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_pc  <= w_win_pc;
            r_src <= w_win_src;
            if ((w_win_src == RDR_PRIV) && !bus.store_empty) begin
              r_state <= DRAIN;
              r_hold  <= 1'b1;
            end else begin
              r_state <= HOLD;
              r_valid <= 1'b1;
              r_flush <= src_onehot(w_win_src);
            end
          end
        end
        DRAIN: begin
          // An exception at WB kills the privileged instruction itself.
          if (bus.wb_excp_req) begin
            r_state <= HOLD;
            r_pc    <= bus.wb_excp_pc;
            r_src   <= RDR_WB;
            r_valid <= 1'b1;
            r_hold  <= 1'b0;
            r_flush <= src_onehot(RDR_WB);
          end else if (bus.store_empty) begin
            // commit_hold stays up through the flush_by_priv cycle.
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_flush <= src_onehot(RDR_PRIV);
          end
        end
        HOLD: begin
          r_hold <= 1'b0;
          if (w_overwrite) begin
            r_pc    <= w_win_pc;
            r_src   <= w_win_src;
            r_flush <= src_onehot(w_win_src);
          end else if (bus.if0_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flush_from_wb  = r_flush[3];
  assign bus.flush_by_priv  = r_flush[2];
  assign bus.flush_from_ex2 = r_flush[1];
  assign bus.flush_from_ex1 = r_flush[0];
  assign bus.redirect_valid = r_valid;
  assign bus.redirect_pc    = r_pc;
  assign bus.commit_hold    = r_hold;
  assign o_dbg_state        = r_state;

`ifdef REDIRECT_STAT_EN
  redirect_stat u_stat (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (r_flush),
    .i_draining  (r_state == DRAIN),
    .o_cnt_wb    (stat_wb_cnt),
    .o_cnt_priv  (stat_priv_cnt),
    .o_cnt_ex2   (stat_ex2_cnt),
    .o_cnt_ex1   (stat_ex1_cnt),
    .o_cnt_drain (stat_drain_cnt)
  );
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_redirect_ctrl: self-checking bench for redirect_ctrl. Expected
// {flush vector, redirect_pc} entries are queued when a request is driven and
// popped when the flush pulse appears.
// -----------------------------------------------------------------------------
module tb_redirect_ctrl;
  import cpu_pkg::*;

  localparam int W = 4 + 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  rdr_state_e dbg_state;
`ifdef REDIRECT_STAT_EN
  logic [31:0] st_wb, st_priv, st_ex2, st_ex1, st_drain;
`endif

  redirect_ctrl_if #(.PC_W(32)) bus ();

  redirect_ctrl #(.PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef REDIRECT_STAT_EN
    ,
    .stat_wb_cnt    (st_wb),
    .stat_priv_cnt  (st_priv),
    .stat_ex2_cnt   (st_ex2),
    .stat_ex1_cnt   (st_ex1),
    .stat_drain_cnt (st_drain)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_v;
  logic [W-1:0] exp_v;

  wire [3:0] obs_fl = {bus.flush_from_wb, bus.flush_by_priv, bus.flush_from_ex2, bus.flush_from_ex1};

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.wb_excp_req = 1'b0; bus.wb_excp_pc = '0;
    bus.ex2_br_req  = 1'b0; bus.ex2_br_pc  = '0;
    bus.ex1_br_req  = 1'b0; bus.ex1_br_pc  = '0;
    bus.priv_req    = 1'b0; bus.priv_pc    = '0;
    bus.store_empty = 1'b1;
    bus.if0_ready   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_in();
    rst = 1'b1;
    tick();
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL rst_flush got=%b exp=%b", obs_fl, 4'b0); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.redirect_pc); end
    total++; if (bus.commit_hold !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b exp=0", bus.commit_hold); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
    rst = 1'b0;
    tick();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%b exp=0", bus.redirect_valid); end
  endtask

  task automatic test_ex1_single();
    clr_in();
    bus.if0_ready = 1'b1;
    bus.ex1_br_req = 1'b1; bus.ex1_br_pc = 32'h1c00_0100;
    exp_q.push_back({4'b0001, 32'h1c00_0100});
    tick();
    bus.ex1_br_req = 1'b0;
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL ex1_sb got=%h exp=%h", got_v, exp_v); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL ex1_valid got=%b exp=1", bus.redirect_valid); end
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL ex1_pulse_len got=%b exp=0000", obs_fl); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL ex1_valid_drop got=%b exp=0", bus.redirect_valid); end
  endtask

  task automatic test_same_cycle();
    clr_in();
    bus.if0_ready = 1'b1;
    bus.ex1_br_req = 1'b1; bus.ex1_br_pc = 32'h1c00_0200;
    bus.wb_excp_req = 1'b1; bus.wb_excp_pc = 32'h1c00_8000;
    exp_q.push_back({4'b1000, 32'h1c00_8000});
    tick();
    clr_in();
    bus.if0_ready = 1'b1;
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL same_cycle_sb got=%h exp=%h", got_v, exp_v); end
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL same_cycle_extra got=%b exp=0000", obs_fl); end
  endtask

  task automatic test_overwrite();
    clr_in();
    bus.ex1_br_req = 1'b1; bus.ex1_br_pc = 32'h100;
    exp_q.push_back({4'b0001, 32'h100});
    tick();
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL ow_first_sb got=%h exp=%h", got_v, exp_v); end
    bus.ex1_br_req = 1'b0;
    bus.ex2_br_req = 1'b1; bus.ex2_br_pc = 32'h200;
    exp_q.push_back({4'b0010, 32'h200});
    tick();
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL ow_ex2_sb got=%h exp=%h", got_v, exp_v); end
    bus.ex2_br_req = 1'b0;
    bus.ex1_br_req = 1'b1; bus.ex1_br_pc = 32'h300;   // younger: ignored
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL ow_lower_flush got=%b exp=0000", obs_fl); end
    total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL ow_lower_pc got=%h exp=200", bus.redirect_pc); end
    bus.ex1_br_req = 1'b0;
    bus.ex2_br_req = 1'b1; bus.ex2_br_pc = 32'h250;   // equal rank: ignored
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL ow_equal_flush got=%b exp=0000", obs_fl); end
    total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL ow_equal_pc got=%h exp=200", bus.redirect_pc); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL ow_valid_held got=%b exp=1", bus.redirect_valid); end
    // Older request in the same cycle as if0_ready: new target must survive.
    bus.ex2_br_req = 1'b0;
    bus.wb_excp_req = 1'b1; bus.wb_excp_pc = 32'h1c00_0900;
    bus.if0_ready = 1'b1;
    exp_q.push_back({4'b1000, 32'h1c00_0900});
    tick();
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL ow_ready_sb got=%h exp=%h", got_v, exp_v); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL ow_ready_valid got=%b exp=1", bus.redirect_valid); end
    total++; if (dbg_state !== HOLD) begin bad++; $display("FAIL ow_ready_state got=%0d exp=%0d", dbg_state, HOLD); end
    bus.wb_excp_req = 1'b0;
    tick();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL ow_done_valid got=%b exp=0", bus.redirect_valid); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL ow_done_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_priv_drain();
    clr_in();
    bus.priv_req = 1'b1; bus.priv_pc = 32'h404; bus.store_empty = 1'b0;
    tick();
    bus.priv_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.commit_hold !== 1'b1) begin bad++; $display("FAIL drain_hold_%0d got=%b exp=1", i, bus.commit_hold); end
      total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL drain_flush_%0d got=%b exp=0000", i, obs_fl); end
      total++; if (dbg_state !== DRAIN) begin bad++; $display("FAIL drain_state_%0d got=%0d exp=%0d", i, dbg_state, DRAIN); end
      if (i == 2) begin
        bus.store_empty = 1'b1;
        exp_q.push_back({4'b0100, 32'h404});
      end
      tick();
    end
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL drain_sb got=%h exp=%h", got_v, exp_v); end
    total++; if (bus.commit_hold !== 1'b1) begin bad++; $display("FAIL drain_hold_pulse got=%b exp=1", bus.commit_hold); end
    tick();
    total++; if (bus.commit_hold !== 1'b0) begin bad++; $display("FAIL drain_hold_end got=%b exp=0", bus.commit_hold); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL drain_valid_held got=%b exp=1", bus.redirect_valid); end
    bus.if0_ready = 1'b1;
    tick();
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL drain_valid_end got=%b exp=0", bus.redirect_valid); end
  endtask

  task automatic test_drain_abort();
    clr_in();
    bus.priv_req = 1'b1; bus.priv_pc = 32'h404; bus.store_empty = 1'b0;
    tick();
    bus.priv_req = 1'b0;
    bus.wb_excp_req = 1'b1; bus.wb_excp_pc = 32'h1c00_8000;
    exp_q.push_back({4'b1000, 32'h1c00_8000});
    tick();
    bus.wb_excp_req = 1'b0;
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL abort_sb got=%h exp=%h", got_v, exp_v); end
    total++; if (bus.commit_hold !== 1'b0) begin bad++; $display("FAIL abort_hold got=%b exp=0", bus.commit_hold); end
    bus.store_empty = 1'b1;
    bus.if0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL abort_no_priv_%0d got=%b exp=0000", i, obs_fl); end
    end
  endtask

  task automatic test_priv_immediate();
    clr_in();
    bus.if0_ready = 1'b1;
    bus.priv_req = 1'b1; bus.priv_pc = 32'h1c00_0404;
    exp_q.push_back({4'b0100, 32'h1c00_0404});
    tick();
    bus.priv_req = 1'b0;
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL priv_imm_sb got=%h exp=%h", got_v, exp_v); end
    total++; if (bus.commit_hold !== 1'b0) begin bad++; $display("FAIL priv_imm_hold got=%b exp=0", bus.commit_hold); end
    tick();
  endtask

  task automatic test_reset_midway();
    clr_in();
    bus.ex2_br_req = 1'b1; bus.ex2_br_pc = 32'h1c00_0a00;
    exp_q.push_back({4'b0010, 32'h1c00_0a00});
    tick();
    bus.ex2_br_req = 1'b0;
    got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
    total++; if (got_v !== exp_v) begin bad++; $display("FAIL rst_hold_sb got=%h exp=%h", got_v, exp_v); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_hold_pc got=%h exp=0", bus.redirect_pc); end
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL rst_hold_flush got=%b exp=0000", obs_fl); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_hold_after_%0d got=%b exp=0", i, bus.redirect_valid); end
    end
    // Reset while draining.
    bus.priv_req = 1'b1; bus.priv_pc = 32'h404; bus.store_empty = 1'b0;
    tick();
    bus.priv_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.commit_hold !== 1'b0) begin bad++; $display("FAIL rst_drain_hold got=%b exp=0", bus.commit_hold); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_drain_state got=%0d exp=%0d", dbg_state, IDLE); end
    tick();
    rst = 1'b0;
    bus.store_empty = 1'b1;
    tick();
    total++; if (obs_fl !== 4'b0) begin bad++; $display("FAIL rst_drain_flush got=%b exp=0000", obs_fl); end
  endtask

  // Random same-cycle request mixes, issued back to back with IDLE re-entry.
  task automatic test_random_priority();
    logic [3:0]  mask;
    logic [31:0] pcs [4];
    for (int it = 0; it < 16; it++) begin
      clr_in();
      bus.if0_ready = 1'b1;
      mask = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) pcs[k] = $urandom;
      bus.ex1_br_req  = mask[0]; bus.ex1_br_pc  = pcs[0];
      bus.ex2_br_req  = mask[1]; bus.ex2_br_pc  = pcs[1];
      bus.priv_req    = mask[2]; bus.priv_pc    = pcs[2];
      bus.wb_excp_req = mask[3]; bus.wb_excp_pc = pcs[3];
      if (mask[3])      exp_q.push_back({4'b1000, pcs[3]});
      else if (mask[2]) exp_q.push_back({4'b0100, pcs[2]});
      else if (mask[1]) exp_q.push_back({4'b0010, pcs[1]});
      else              exp_q.push_back({4'b0001, pcs[0]});
      tick();
      clr_in();
      bus.if0_ready = 1'b1;
      got_v = {obs_fl, bus.redirect_pc}; exp_v = exp_q.pop_front();
      total++; if (got_v !== exp_v) begin bad++; $display("FAIL rand_%0d_sb mask=%b got=%h exp=%h", it, mask, got_v, exp_v); end
      tick();
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rand_%0d_valid got=%b exp=0", it, bus.redirect_valid); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_ex1_single();
    test_same_cycle();
    test_overwrite();
    test_priv_drain();
    test_drain_abort();
    test_priv_immediate();
    test_reset_midway();
    test_random_priority();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Frontend-redirect initiator for the pipeline flush network. Collects redirect requests from WB (exception/ertn), EX2 and EX1 (branch mispredict) and privileged-op commits, picks the oldest, and issues one-cycle `flush_from_*`/`flush_by_priv` pulses to the hazard unit. Holds the redirect PC toward IF0 until accepted. Sequences privileged refetches: commit stall until the store buffer drains.

## Interface
- `PC_W`, 32, PC width
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `wb_excp_req`  in  1  exception/ertn at WB
- `wb_excp_pc`  in  PC_W  exception entry / era target
- `ex2_br_req`  in  1  EX2 mispredict
- `ex2_br_pc`  in  PC_W  EX2 correct target
- `ex1_br_req`  in  1  EX1 mispredict
- `ex1_br_pc`  in  PC_W  EX1 correct target
- `priv_req`  in  1  CSR write / ibar / TLB op committing; needs refetch
- `priv_pc`  in  PC_W  refetch PC (instr PC + 4)
- `store_empty`  in  1  store buffer / dcache write path idle
- `if0_ready`  in  1  IF0 accepts redirect this cycle
- `flush_from_wb`, `flush_from_ex2`, `flush_from_ex1`, `flush_by_priv`  out  1 each  one-cycle flush pulses
- `redirect_valid`  out  1  redirect pending to IF0
- `redirect_pc`  out  PC_W  redirect target
- `commit_hold`  out  1  stall EX2→WB during privileged drain

## Operation
- Source rank, oldest first: WB=3, PRIV=2, EX2=1, EX1=0. Same-cycle requests: highest rank wins; others dropped.
- FSM `IDLE`, `DRAIN`, `HOLD`.
- IDLE:
  - WB/EX2/EX1 winner → register PC and rank, pulse matching flush next cycle, go HOLD.
  - PRIV winner with `store_empty`=1 → pulse `flush_by_priv`, go HOLD.
  - PRIV winner with `store_empty`=0 → go DRAIN.
- DRAIN:
  - `commit_hold`=1. Latch `priv_pc`.
  - `store_empty`=1 → pulse `flush_by_priv`, go HOLD.
  - `wb_excp_req` aborts the drain: WB flush, go HOLD. Other requests are ignored.
- HOLD:
  - `redirect_valid`=1.
  - A request of strictly higher rank than the pending one overwrites PC/rank, issues its flush pulse, and stays in HOLD. Equal or lower rank is ignored.
  - `if0_ready`=1 with no overwrite that cycle → IDLE. With an overwrite the same cycle, the new PC is retained and the state stays HOLD.
- At most one flush output is high in any cycle.
- PCs pass through unmodified. No arithmetic.

## Timing
- Reset: state IDLE; all flush outputs, `redirect_valid`, `commit_hold` = 0; `redirect_pc` = 0.
- Request in cycle N → flush pulse and `redirect_valid` in cycle N+1 (registered outputs).
- `redirect_valid`/`redirect_pc` remain stable until the `if0_ready` handshake completes. The earliest IDLE return is N+2.
- `commit_hold` is asserted from the cycle after entering DRAIN through the cycle `flush_by_priv` pulses.
- Reset mid-DRAIN or mid-HOLD discards the pending redirect immediately.

## Configuration
- `REDIRECT_STAT_EN` defined: four 32-bit saturating counters, one per source, each incrementing on its flush pulse. Also a 32-bit drain-cycle counter. Counters are reset by `rst` and readable on `stat_*` output ports.
- Undefined: no counters and no `stat_*` ports. Functional behaviour is identical.

## Structure
- Shared package `cpu_pkg`: redirect-source rank enum (`RDR_EX1`..`RDR_WB`), FSM state enum, `PC_W` default.
- One sub-module, `redirect_stat`: counter bank, instantiated only under `REDIRECT_STAT_EN`.

## Test plan
- `ex1_br_req`=1, pc=0x1c000100, `if0_ready`=1 → next cycle: `flush_from_ex1`=1 for one cycle, `redirect_pc`=0x1c000100, `redirect_valid` for 1 cycle.
- `ex1_br_req` and `wb_excp_req` (pc=0x1c008000) in the same cycle → only `flush_from_wb` pulses; `redirect_pc`=0x1c008000.
- Sequence:
  - `ex1_br_req` (0x100) with `if0_ready`=0.
  - Next cycle `ex2_br_req` (0x200) → `flush_from_ex2` pulses and `redirect_pc`=0x200.
  - A following `ex1_br_req` (0x300) is ignored.
- Sequence:
  - `priv_req` (0x404) with `store_empty`=0 for 3 cycles → `commit_hold`=1 for 3 cycles.
  - `store_empty`=1 → `flush_by_priv` pulses and `redirect_pc`=0x404.
- `wb_excp_req` during DRAIN → drain aborted, `flush_from_wb` pulses, `flush_by_priv` never asserts.
- `rst` asserted in HOLD → all outputs 0 the same cycle; after release, `redirect_valid` stays 0.
